muldiv_unit: RTL and testbench
==============================

Name: muldiv_unit

Overview:
- Iterative RV64M multiply/divide unit.
- Decodes func_3 and the W-variant flag for the M-extension, runs a multi-cycle shift-add multiply or restoring divide, and returns the result through a valid/ready style handshake.
- Sits beside the single-cycle ALU in the execute stage. The control FSM stalls on o_ready/o_valid.
- Parametrised in data width. Adds W-variant, special-case and flush behaviour.

Parameters:
- XLEN, 64, datapath width (power of two, >= 32).

Ports:
- i_clk  input  1  clock; all state updates on rising edge
- i_arst_n  input  1  asynchronous active-low reset
- i_valid  input  1  start request; accepted when i_valid && o_ready
- i_func_3  input  3  M-ext func_3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- i_op_w  input  1  W variant (MULW/DIVW/DIVUW/REMW/REMUW)
- i_flush  input  1  abort any operation in progress
- i_src_1  input  XLEN  rs1 operand
- i_src_2  input  XLEN  rs2 operand
- o_ready  output  1  unit idle, can accept
- o_valid  output  1  one-cycle pulse, o_result valid
- o_result  output  XLEN  result, held until next accept
- o_illegal_instr  output  1  one-cycle pulse on accepted illegal encoding

Behaviour:
- Reset (async, i_arst_n low):
  - state=IDLE; o_ready=1; o_valid=0; o_result=0; o_illegal_instr=0; counter and datapath registers cleared.
- States: IDLE, MUL, DIV, DONE.
- Accept in IDLE with i_valid=1 and i_flush=0:
  - Latch operands, func_3 and op_w.
  - o_ready drops the following cycle.
- Illegal: i_op_w=1 with func_3 in {001,010,011}.
  - o_illegal_instr=1 the cycle after accept.
  - State stays IDLE, o_valid stays 0, o_result is unchanged.
- Operand preparation at accept:
  - W: use bits [31:0], sign- or zero-extended per signedness to XLEN.
  - Signed ops: store absolute values and record the result sign.
  - Signedness: MULH signed x signed; MULHSU signed x unsigned; MULHU unsigned; DIV/REM signed; DIVU/REMU unsigned; MUL sign-agnostic (low half).
- MUL state:
  - One shift-add step per cycle into a 2*XLEN accumulator.
  - N iterations, with N=XLEN, or 32 for W.
  - Then DONE.
- DIV state:
  - One restoring step per cycle producing one quotient bit.
  - N iterations.
  - Then DONE.
- Counter width: $clog2(XLEN)+1. Loads N at accept and decrements per step. The step with counter==1 is the last one.
- Division special cases, detected at accept. These skip DIV and go directly to DONE (2-cycle latency):
  - Divisor zero: quotient = all ones; remainder = dividend.
  - Signed overflow (most-negative / -1, at the effective width): quotient = dividend; remainder = 0.
- DONE (one cycle):
  - Apply sign correction (two's-complement negate when the recorded sign is negative).
  - Select the result:
    - MUL: low XLEN bits.
    - MULH*: high XLEN bits.
    - DIV*: quotient.
    - REM*: remainder.
  - W: result[31:0] sign-extended to XLEN.
  - Register o_result, pulse o_valid=1, return to IDLE (o_ready=1 the next cycle).
- Latency from accept to o_valid:
  - N+2 cycles for the iterative path.
  - 2 cycles for division special cases.
- Back-to-back operation: a new accept is allowed on the cycle after o_valid.
- Remainder sign follows the dividend; quotient sign is the XOR of the operand signs.
- i_flush:
  - In MUL/DIV/DONE: next state IDLE, no o_valid, o_result keeps its previous value.
  - In IDLE with i_valid: flush wins, nothing is accepted.
- i_valid while not ready is ignored; operands are not re-sampled.
- Async reset mid-operation: immediate return to the reset values, and no o_valid afterwards.

Test Plan:
- Reset, then MUL 7 x -3 (i_op_w=0) -> o_valid 66 cycles after accept, o_result=0xFFFFFFFFFFFFFFEB; o_ready=1 the following cycle.
- MULHU 0xFFFFFFFFFFFFFFFF x 0xFFFFFFFFFFFFFFFF -> 0xFFFFFFFFFFFFFFFE. MULH -1 x -1 -> 0. MULHSU -1 x 2 -> 0xFFFFFFFFFFFFFFFF.
- DIV -7 / 2 -> -3; REM -7 / 2 -> -1; DIVU 100 / 7 -> 14; REMU 100 / 7 -> 2; each with 66-cycle latency.
- DIV x / 0 -> 0xFFFFFFFFFFFFFFFF and REM x / 0 -> x. DIV 0x8000000000000000 / -1 -> 0x8000000000000000, REM -> 0. Both with 2-cycle latency.
- W variants:
  - DIVW 0x00000000_80000000 / -1 -> 0xFFFFFFFF80000000 in 2 cycles.
  - MULW 0x10000 x 0x10000 -> 0 in 34 cycles.
  - i_op_w=1 with func_3=001 -> o_illegal_instr pulse, no o_valid.
- Flush and reset mid-operation:
  - i_flush 10 cycles into a DIV -> o_ready=1 next cycle, no o_valid, o_result unchanged.
  - i_arst_n low mid-MUL -> all outputs at reset values immediately.

Source files
------------

// File: rtl/muldiv_unit.sv
// Iterative RV64M multiply/divide unit: shift-add multiply, restoring divide,
// W variants, early-out division special cases and flush.
module muldiv_unit #(
    parameter int XLEN = 64
) (
    input  logic            i_clk,
    input  logic            i_arst_n,
    input  logic            i_valid,
    input  logic [2:0]      i_func_3,
    input  logic            i_op_w,
    input  logic            i_flush,
    input  logic [XLEN-1:0] i_src_1,
    input  logic [XLEN-1:0] i_src_2,
    output logic            o_ready,
    output logic            o_valid,
    output logic [XLEN-1:0] o_result,
    output logic            o_illegal_instr
);
    localparam int CW = $clog2(XLEN) + 1;
    localparam logic [XLEN-1:0] MIN_X = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] MIN_W = {{(XLEN-31){1'b1}}, 31'd0};

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;
    state_t state, state_nxt;

    logic [2:0]        f3;
    logic              op_w;
    logic              neg_q;
    logic              neg_r;
    logic [XLEN-1:0]   op_a;
    logic [XLEN-1:0]   op_b;
    logic [2*XLEN-1:0] acc;
    logic [CW-1:0]     cnt;

    logic              accept;
    logic              illegal;
    logic              is_div;
    logic              sgn_a;
    logic              sgn_b;
    logic              div_zero;
    logic              div_ovf;
    logic              sign_a;
    logic              sign_b;
    logic [XLEN-1:0]   ext_a;
    logic [XLEN-1:0]   ext_b;
    logic [XLEN-1:0]   abs_a;
    logic [XLEN-1:0]   abs_b;
    logic [2*XLEN-1:0] acc_init;
    logic [CW-1:0]     n_iter;

    assign o_ready = (state == IDLE);
    assign accept  = i_valid && o_ready && !i_flush;

    always_comb begin
        illegal = i_op_w && !i_func_3[2] && (i_func_3[1:0] != 2'b00);
        is_div  = i_func_3[2];
        sgn_a   = (i_func_3 == 3'b001) || (i_func_3 == 3'b010)
               || (i_func_3[2] && !i_func_3[0]);
        sgn_b   = (i_func_3 == 3'b001) || (i_func_3[2] && !i_func_3[0]);
        ext_a   = i_src_1;
        ext_b   = i_src_2;
        if (i_op_w) begin
            ext_a = {{(XLEN-32){sgn_a && i_src_1[31]}}, i_src_1[31:0]};
            ext_b = {{(XLEN-32){sgn_b && i_src_2[31]}}, i_src_2[31:0]};
        end
        sign_a   = sgn_a && ext_a[XLEN-1];
        sign_b   = sgn_b && ext_b[XLEN-1];
        abs_a    = sign_a ? -ext_a : ext_a;
        abs_b    = sign_b ? -ext_b : ext_b;
        div_zero = is_div && (ext_b == '0);
        div_ovf  = is_div && sgn_b && (&ext_b)
                && (ext_a == (i_op_w ? MIN_W : MIN_X));
        n_iter   = i_op_w ? CW'(32) : CW'(XLEN);
        // W divide runs 32 steps, so the dividend starts in the top word
        if (div_zero)
            acc_init = {ext_a, {XLEN{1'b1}}};
        else if (div_ovf)
            acc_init = {{XLEN{1'b0}}, ext_a};
        else if (is_div)
            acc_init = {{XLEN{1'b0}}, i_op_w ? (abs_a << 32) : abs_a};
        else
            acc_init = {{XLEN{1'b0}}, abs_b};
    end

    logic [XLEN:0] mul_sum;
    logic [XLEN:0] div_sh;
    logic [XLEN:0] div_diff;
    logic          div_ge;

    always_comb begin
        mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]}
                 + (acc[0] ? {1'b0, op_a} : '0);
        div_sh   = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
        div_diff = div_sh - {1'b0, op_b};
        div_ge   = !div_diff[XLEN];
    end

    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quo;
    logic [XLEN-1:0]   rem;
    logic [XLEN-1:0]   mul_lo;
    logic [XLEN-1:0]   raw;
    logic [XLEN-1:0]   res;

    always_comb begin
        prod   = neg_q ? -acc : acc;
        quo    = neg_q ? -acc[XLEN-1:0] : acc[XLEN-1:0];
        rem    = neg_r ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
        // after 32 steps the low product word sits just below the midline
        mul_lo = op_w ? {{(XLEN-32){1'b0}}, prod[XLEN-1 -: 32]}
                      : prod[XLEN-1:0];
        raw = '0;
        unique case (1'b1)
            f3 == 3'b000:                 raw = mul_lo;
            !f3[2] && (f3[1:0] != 2'b00): raw = prod[2*XLEN-1:XLEN];
            f3[2] && !f3[1]:              raw = quo;
            f3[2] && f3[1]:               raw = rem;
            default:                      raw = '0;
        endcase
        res = op_w ? {{(XLEN-32){raw[31]}}, raw[31:0]} : raw;
    end

    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (accept && !illegal) begin
                    if (!is_div)
                        state_nxt = MUL;
                    else if (div_zero || div_ovf)
                        state_nxt = DONE;
                    else
                        state_nxt = DIV;
                end
            end
            MUL:     if (cnt == CW'(1)) state_nxt = DONE;
            DIV:     if (cnt == CW'(1)) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (i_flush)
            state_nxt = IDLE;
    end

    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            f3              <= '0;
            op_w            <= 1'b0;
            neg_q           <= 1'b0;
            neg_r           <= 1'b0;
            op_a            <= '0;
            op_b            <= '0;
            acc             <= '0;
            cnt             <= '0;
            o_valid         <= 1'b0;
            o_result        <= '0;
            o_illegal_instr <= 1'b0;
        end else begin
            o_valid         <= 1'b0;
            o_illegal_instr <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (accept && illegal) begin
                        o_illegal_instr <= 1'b1;
                    end else if (accept) begin
                        f3    <= i_func_3;
                        op_w  <= i_op_w;
                        op_a  <= abs_a;
                        op_b  <= abs_b;
                        cnt   <= n_iter;
                        acc   <= acc_init;
                        neg_q <= !(div_zero || div_ovf) && (sign_a ^ sign_b);
                        neg_r <= !(div_zero || div_ovf) && sign_a;
                    end
                end
                MUL: begin
                    acc <= {mul_sum, acc[XLEN-1:1]};
                    cnt <= cnt - CW'(1);
                end
                DIV: begin
                    acc <= {div_ge ? div_diff[XLEN-1:0] : div_sh[XLEN-1:0],
                            acc[XLEN-2:0], div_ge};
                    cnt <= cnt - CW'(1);
                end
                DONE: begin
                    if (!i_flush) begin
                        o_valid  <= 1'b1;
                        o_result <= res;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: directed cases, flush, reset and
// randomized ops checked against a plain-arithmetic reference model.
module tb_muldiv_unit;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_valid = 1'b0;
    logic [2:0]  i_func_3 = '0;
    logic        i_op_w = 1'b0;
    logic        i_flush = 1'b0;
    logic [63:0] i_src_1 = '0;
    logic [63:0] i_src_2 = '0;
    logic        o_ready;
    logic        o_valid;
    logic [63:0] o_result;
    logic        o_illegal_instr;

    always #5 clk = ~clk;

    muldiv_unit #(.XLEN(64)) dut (
        .i_clk          (clk),
        .i_arst_n       (rst_n),
        .i_valid        (i_valid),
        .i_func_3       (i_func_3),
        .i_op_w         (i_op_w),
        .i_flush        (i_flush),
        .i_src_1        (i_src_1),
        .i_src_2        (i_src_2),
        .o_ready        (o_ready),
        .o_valid        (o_valid),
        .o_result       (o_result),
        .o_illegal_instr(o_illegal_instr)
    );

    typedef struct {
        logic [63:0] res;
        int          lat;
        logic        ill;
        int          acc_cyc;
    } exp_t;

    exp_t        q[$];
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    logic [63:0] last_res = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, want);
        end
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst_n && (o_valid || o_illegal_instr)) begin
            if (q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_output: got valid=%0b illegal=%0b want none",
                         o_valid, o_illegal_instr);
            end else begin
                e = q.pop_front();
                chk("kind", {62'd0, o_valid, o_illegal_instr},
                    e.ill ? 64'd1 : 64'd2);
                chk("latency", 64'(cyc - e.acc_cyc), 64'(e.lat));
                if (!e.ill) begin
                    chk("result", o_result, e.res);
                    last_res = e.res;
                end
            end
        end
    end

    function automatic logic model_ill(input logic [2:0] f, input logic w);
        return w && !f[2] && (f[1:0] != 2'b00);
    endfunction

    function automatic int model_lat(input logic [2:0] f, input logic w,
                                     input logic [63:0] a, input logic [63:0] b);
        logic [63:0] ea, eb, mn, ones;
        if (model_ill(f, w)) return 1;
        ea   = w ? {32'd0, a[31:0]} : a;
        eb   = w ? {32'd0, b[31:0]} : b;
        mn   = w ? 64'h8000_0000 : 64'h8000_0000_0000_0000;
        ones = w ? 64'hFFFF_FFFF : '1;
        if (f[2] && (eb == 0 || (!f[0] && ea == mn && eb == ones))) return 2;
        return w ? 34 : 66;
    endfunction

    function automatic logic [63:0] model_res(input logic [2:0] f, input logic w,
                                              input logic [63:0] a,
                                              input logic [63:0] b);
        logic [127:0]       p;
        logic [63:0]        r;
        logic [31:0]        a32, b32, r32;
        logic signed [63:0] sa, sb;
        logic signed [31:0] sa32, sb32;
        logic               ovf, ovf32;
        a32   = a[31:0];
        b32   = b[31:0];
        sa    = a;
        sb    = b;
        sa32  = a32;
        sb32  = b32;
        ovf   = (a == 64'h8000_0000_0000_0000) && (b == '1);
        ovf32 = (a32 == 32'h8000_0000) && (b32 == '1);
        r     = '0;
        r32   = '0;
        p     = '0;
        if (!w) begin
            case (f)
                3'd0: begin p = {64'd0, a} * {64'd0, b}; r = p[63:0]; end
                3'd1: begin p = {{64{a[63]}}, a} * {{64{b[63]}}, b}; r = p[127:64]; end
                3'd2: begin p = {{64{a[63]}}, a} * {64'd0, b}; r = p[127:64]; end
                3'd3: begin p = {64'd0, a} * {64'd0, b}; r = p[127:64]; end
                3'd4: if (b == 0) r = '1; else if (ovf) r = a; else r = sa / sb;
                3'd5: if (b == 0) r = '1; else r = a / b;
                3'd6: if (b == 0) r = a; else if (ovf) r = '0; else r = sa % sb;
                default: if (b == 0) r = a; else r = a % b;
            endcase
        end else begin
            case (f)
                3'd0: r32 = a32 * b32;
                3'd4: if (b32 == 0) r32 = '1; else if (ovf32) r32 = a32; else r32 = sa32 / sb32;
                3'd5: if (b32 == 0) r32 = '1; else r32 = a32 / b32;
                3'd6: if (b32 == 0) r32 = a32; else if (ovf32) r32 = '0; else r32 = sa32 % sb32;
                3'd7: if (b32 == 0) r32 = a32; else r32 = a32 % b32;
                default: r32 = '0;
            endcase
            r = {{32{r32[31]}}, r32};
        end
        return r;
    endfunction

    function automatic logic [63:0] rnd_op();
        case ($urandom_range(0, 6))
            0: return 64'd0;
            1: return '1;
            2: return 64'h8000_0000_0000_0000;
            3: return 64'($urandom_range(0, 20));
            4: return {$urandom, 32'h8000_0000};
            default: return {$urandom, $urandom};
        endcase
    endfunction

    task automatic issue(input logic [2:0] f, input logic w,
                         input logic [63:0] a, input logic [63:0] b,
                         input logic track, input logic [63:0] xres,
                         input int lat, input logic ill);
        exp_t e;
        @(negedge clk);
        i_valid  = 1'b1;
        i_func_3 = f;
        i_op_w   = w;
        i_src_1  = a;
        i_src_2  = b;
        if (track) begin
            e.res     = xres;
            e.lat     = lat;
            e.ill     = ill;
            e.acc_cyc = cyc;
            q.push_back(e);
        end
        @(negedge clk);
        i_valid = 1'b0;
        chk("ready_after_accept", {63'd0, o_ready}, {63'd0, ill});
        if (track && !ill && $urandom_range(0, 1) == 1) begin
            i_valid  = 1'b1;
            i_func_3 = 3'($urandom);
            i_src_1  = {$urandom, $urandom};
            i_src_2  = {$urandom, $urandom};
            @(negedge clk);
            i_valid = 1'b0;
        end
    endtask

    task automatic drain();
        int n = 0;
        #1;
        while (q.size() != 0 && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL timeout: got %0d pending want 0", q.size());
            q.delete();
        end
        @(negedge clk);
        chk("ready_after_done", {63'd0, o_ready}, 64'd1);
    endtask

    task automatic run_dir(input logic [2:0] f, input logic w,
                           input logic [63:0] a, input logic [63:0] b,
                           input logic [63:0] xres, input int lat,
                           input logic ill);
        issue(f, w, a, b, 1'b1, xres, lat, ill);
        drain();
    endtask

    task automatic run_rand(input logic [2:0] f, input logic w,
                            input logic [63:0] a, input logic [63:0] b);
        issue(f, w, a, b, 1'b1, model_res(f, w, a, b),
              model_lat(f, w, a, b), model_ill(f, w));
        drain();
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("reset_ready", {63'd0, o_ready}, 64'd1);
        chk("reset_valid", {63'd0, o_valid}, 64'd0);
        chk("reset_result", o_result, 64'd0);
        chk("reset_illegal", {63'd0, o_illegal_instr}, 64'd0);
        rst_n = 1'b1;

        run_dir(3'd0, 0, 64'd7, -64'sd3, 64'hFFFF_FFFF_FFFF_FFEB, 66, 0);
        run_dir(3'd3, 0, '1, '1, 64'hFFFF_FFFF_FFFF_FFFE, 66, 0);
        run_dir(3'd1, 0, '1, '1, 64'd0, 66, 0);
        run_dir(3'd2, 0, '1, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 66, 0);
        run_dir(3'd4, 0, -64'sd7, 64'd2, -64'sd3, 66, 0);
        run_dir(3'd6, 0, -64'sd7, 64'd2, -64'sd1, 66, 0);
        run_dir(3'd5, 0, 64'd100, 64'd7, 64'd14, 66, 0);
        run_dir(3'd7, 0, 64'd100, 64'd7, 64'd2, 66, 0);
        run_dir(3'd4, 0, 64'h123, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 2, 0);
        run_dir(3'd6, 0, 64'h123, 64'd0, 64'h123, 2, 0);
        run_dir(3'd4, 0, 64'h8000_0000_0000_0000, '1,
                64'h8000_0000_0000_0000, 2, 0);
        run_dir(3'd6, 0, 64'h8000_0000_0000_0000, '1, 64'd0, 2, 0);
        run_dir(3'd4, 1, 64'h0000_0000_8000_0000, '1,
                64'hFFFF_FFFF_8000_0000, 2, 0);
        run_dir(3'd0, 1, 64'h10000, 64'h10000, 64'd0, 34, 0);
        run_dir(3'd1, 1, 64'd5, 64'd6, 64'd0, 1, 1);

        // flush together with a request in IDLE: nothing accepted
        @(negedge clk);
        i_valid  = 1'b1;
        i_flush  = 1'b1;
        i_func_3 = 3'd4;
        i_op_w   = 1'b0;
        i_src_1  = 64'd1000;
        i_src_2  = 64'd3;
        @(negedge clk);
        i_valid = 1'b0;
        i_flush = 1'b0;
        chk("flush_idle_ready", {63'd0, o_ready}, 64'd1);

        // flush ten cycles into a DIV
        issue(3'd4, 0, 64'd1000, 64'd3, 1'b0, '0, 0, 0);
        repeat (9) @(negedge clk);
        i_flush = 1'b1;
        @(negedge clk);
        i_flush = 1'b0;
        chk("flush_div_ready", {63'd0, o_ready}, 64'd1);
        repeat (80) @(negedge clk);
        chk("flush_div_result", o_result, last_res);

        // async reset in the middle of a MUL
        issue(3'd0, 0, 64'd12345, 64'd678, 1'b0, '0, 0, 0);
        repeat (20) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_ready", {63'd0, o_ready}, 64'd1);
        chk("arst_valid", {63'd0, o_valid}, 64'd0);
        chk("arst_result", o_result, 64'd0);
        chk("arst_illegal", {63'd0, o_illegal_instr}, 64'd0);
        last_res = '0;
        @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (80) @(negedge clk);
        chk("arst_after_result", o_result, 64'd0);

        for (int i = 0; i < 60; i++) begin
            run_rand(3'($urandom_range(0, 7)), ($urandom_range(0, 2) == 0),
                     rnd_op(), rnd_op());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
